hkspi_oversampled_slave: RTL
============================

Name: hkspi_oversampled_slave

Overview:
Housekeeping SPI responder: the target end of the serial write/read stream protocol that a host drives on CSB/SCK/SDI/SDO. All SPI pins are oversampled in the system clock domain; there is no SCK clock domain. The block decodes command, address and data bytes and issues single-cycle register strobes onto the housekeeping register bus. It sits between the pad-side SPI pins and the housekeeping register file, including the bit-bang control register at address 0x13.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_csb/spi_sck/spi_sdi (legal values 2-3)
ADDR_W, 8, register address width

Ports:
wb_clk_i  input  1  system clock; all logic on rising edge
wb_rst_i  input  1  reset, synchronous, active-high
spi_csb  input  1  chip select, active-low, asynchronous to wb_clk_i
spi_sck  input  1  SPI clock, asynchronous
spi_sdi  input  1  serial data in, MSB first
spi_sdo  output  1  serial data out, MSB first
spi_sdo_enb  output  1  SDO output enable, active-low
reg_addr  output  ADDR_W  current register address
reg_wdata  output  8  write data, valid while reg_wstb is high
reg_wstb  output  1  one-cycle write strobe
reg_rstb  output  1  one-cycle read request
reg_rdata  input  8  read data, valid the cycle after reg_rstb
busy  output  1  high while CSB is low and a transaction is active

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: spi_sdo=0, spi_sdo_enb=1, reg_addr=0, reg_wdata=0, reg_wstb=0, reg_rstb=0, busy=0, state=IDLE.
- Input sampling: SYNC_STAGES flops on each SPI input, then an edge detector on synced SCK.
- Timing requirement on the host: SCK high time and SCK low time each >= 4 wb_clk_i cycles; CSB setup to the first SCK edge >= 4 cycles.
- SPI mode 0: SDI is captured on SCK rise; SDO changes on SCK fall.
- State IDLE: wait for the synced CSB to fall, then go to CMD with the bit counter cleared.
- State CMD: shift 8 bits, then decode cmd[7:6]:
  - 10 = write stream
  - 01 = read stream
  - 11 = read/write
  - 00 = no-op; go to DONE
  - cmd[5:3] = byte count N (0 = unlimited); used only when the feature macro is defined.
- State ADDR: shift 8 bits into reg_addr. For read modes, pulse reg_rstb on the cycle after the 8th rise is detected, and load the SDO shift register from reg_rdata one cycle later. Go to DATA.
- State DATA, write path: on the detected 8th rise, drive reg_wdata = received byte and pulse reg_wstb for exactly 1 cycle, with reg_addr still equal to the byte's address.
- State DATA, post-byte: reg_addr increments on the cycle after the strobe and wraps 0xFF->0x00. Read modes then pulse reg_rstb and reload the SDO shift register.
- SDO output: spi_sdo_enb goes low from the first SCK fall after the address byte until CSB rises. The shift register MSB is driven on each SCK fall.
- State DONE: ignore SCK; hold until CSB rises.
- CSB rise in any state: return to IDLE next cycle; spi_sdo_enb=1, busy=0. A partial byte is discarded and no strobe is issued.
- Reset asserted mid-transaction: outputs go to reset values. The block stays in IDLE until CSB is seen high and then falls again; it never resumes mid-stream.
- Simultaneous CSB rise and 8th SCK rise in the same synced cycle: CSB wins; no strobe.
- reg_wstb and reg_rstb never assert in the same cycle. In read/write mode the write strobe comes first and the read strobe follows 1 cycle after the address increment.

Optional Feature:
HKSPI_BYTECOUNT_EN
- Defined: a nonzero cmd[5:3]=N limits DATA to N bytes, then the FSM goes to DONE. SDO is tristated (spi_sdo_enb=1) at the first SCK fall after byte N.
- Not defined: cmd[5:3] is ignored and all transfers stream until CSB rises.

Test Plan:
- Write 0x80,0x13,0x66 -> exactly one reg_wstb with reg_addr=0x13, reg_wdata=0x66; busy drops within SYNC_STAGES+2 cycles of CSB rise.
- Stream write 0x80,0x12,0xAA,0x55 -> two strobes: (0x12,0xAA) then (0x13,0x55); final reg_addr=0x14.
- Read 0x40,0x05 with reg_rdata=0x3C for address 0x05 and 0xC3 for 0x06, two data bytes -> SDO bytes 0x3C,0xC3; reg_rstb asserted for 0x05 and 0x06; spi_sdo_enb=1 during cmd and addr.
- Wrap: write 0x80,0xFF,0x01,0x02 -> strobes at 0xFF then 0x00.
- Abort: CSB raised after 5 data bits of 0x80,0x20,0x7x -> no reg_wstb. A following transaction 0x80,0x21,0x99 writes 0x99 to 0x21 correctly.
- Reset: wb_rst_i pulsed after the address byte of a write while CSB is still low -> no strobe, and remaining SCK pulses are ignored. With HKSPI_BYTECOUNT_EN, 0x88,0x20,0x11,0x22 -> only (0x20,0x11) is written.

Source files
------------

// File: rtl/hkspi_oversampled_slave.sv
// Housekeeping SPI responder, SPI mode 0, with all pins oversampled in wb_clk_i.
// It decodes command, address and data bytes into one-cycle strobes on the housekeeping register bus.
// The optional macro HKSPI_BYTECOUNT_EN makes a nonzero cmd[5:3] limit the number of data bytes.
module hkspi_oversampled_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              spi_csb,
  input  logic              spi_sck,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdo_enb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wstb,
  output logic              reg_rstb,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  csb_sync_q, sck_sync_q, sdi_sync_q;
  logic                    csb_prev_q, sck_prev_q;
  logic                    csb_s, sck_s, sdi_s;
  logic                    sck_rise, sck_fall, csb_fall;
  logic                    shifting, bit_rise, byte_done;
  logic                    cmd_done, addr_done, data_done;
  logic [6:0]              shift_q;
  logic [2:0]              bit_cnt_q;
  logic [7:0]              rx_byte;
  logic [1:0]              mode_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [7:0]              wdata_q;
  logic                    wstb_q, rstb_q, ld_q, p1_q, p2_q;
  logic [7:0]              sr_q, sr_src;
  logic                    sdo_q, enb_q;
`ifdef HKSPI_BYTECOUNT_EN
  logic [2:0]              nbytes_q, bcnt_q;
  logic                    limit_hit;
`endif

  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // csb_prev_q resets low, so a fall is only seen after CSB has been observed high
  assign csb_fall = csb_prev_q & ~csb_s;

  assign rx_byte   = {shift_q, sdi_s};
  assign bit_rise  = shifting & sck_rise & ~csb_s;
  assign byte_done = bit_rise & (bit_cnt_q == 3'd7);
  assign cmd_done  = byte_done & (state_q == ST_CMD);
  assign addr_done = byte_done & (state_q == ST_ADDR);
  assign data_done = byte_done & (state_q == ST_DATA);
  // a pending reload may coincide with the SCK fall that must present its MSB
  assign sr_src    = ld_q ? reg_rdata : sr_q;

`ifdef HKSPI_BYTECOUNT_EN
  assign limit_hit = (nbytes_q != 3'd0) && (bcnt_q == nbytes_q - 3'd1);
`endif

  // synchronizers and edge-detect history for the SPI pins
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      csb_sync_q <= '0;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      csb_prev_q <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      csb_prev_q <= csb_s;
      sck_prev_q <= sck_s;
    end
  end

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic; a CSB rise wins over everything, including a completing byte
  always_comb begin
    state_d = state_q;
    if (csb_s && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (csb_fall) state_d = ST_CMD;
        ST_CMD:  if (cmd_done) state_d = (rx_byte[7:6] == 2'b00) ? ST_DONE : ST_ADDR;
        ST_ADDR: if (addr_done) state_d = ST_DATA;
`ifdef HKSPI_BYTECOUNT_EN
        ST_DATA: if (data_done && limit_hit) state_d = ST_DONE;
`else
        ST_DATA: state_d = ST_DATA;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // state-derived outputs
  always_comb begin
    busy     = (state_q != ST_IDLE);
    shifting = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  end

  // shifting, register-bus pipeline and SDO drive
  // data byte done at t: wstb at t+1, address increment visible t+2, rstb t+3, reload t+4
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      mode_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstb_q    <= 1'b0;
      rstb_q    <= 1'b0;
      ld_q      <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      sr_q      <= '0;
      sdo_q     <= 1'b0;
      enb_q     <= 1'b1;
`ifdef HKSPI_BYTECOUNT_EN
      nbytes_q  <= '0;
      bcnt_q    <= '0;
`endif
    end else begin
      if (state_q == ST_IDLE) begin
        bit_cnt_q <= '0;
      end else if (bit_rise) begin
        shift_q   <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (cmd_done) mode_q <= rx_byte[7:6];
      if (addr_done)  addr_q <= ADDR_W'(rx_byte);
      else if (p1_q)  addr_q <= addr_q + ADDR_W'(1);
      p1_q   <= data_done;
      p2_q   <= p1_q;
      wstb_q <= data_done & mode_q[1];
      if (data_done & mode_q[1]) wdata_q <= rx_byte;
      rstb_q <= mode_q[0] & (addr_done | p2_q);
      ld_q   <= rstb_q;
      if (sck_fall && state_q == ST_DATA && !csb_s) begin
        sdo_q <= sr_src[7];
        sr_q  <= {sr_src[6:0], 1'b0};
      end else if (ld_q) begin
        sr_q  <= reg_rdata;
      end
      if (csb_s || state_q == ST_IDLE)            enb_q <= 1'b1;
      else if (sck_fall && state_q == ST_DATA)    enb_q <= 1'b0;
      else if (sck_fall && state_q == ST_DONE)    enb_q <= 1'b1;
`ifdef HKSPI_BYTECOUNT_EN
      if (cmd_done) nbytes_q <= rx_byte[5:3];
      if (state_q == ST_IDLE) bcnt_q <= '0;
      else if (data_done)     bcnt_q <= bcnt_q + 3'd1;
`endif
    end
  end

  assign spi_sdo     = sdo_q;
  assign spi_sdo_enb = enb_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wstb    = wstb_q;
  assign reg_rstb    = rstb_q;

endmodule
